// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the 5-stage RISC-V pipeline.
//   XLEN / ILEN  : datapath and instruction widths (32)
//   NOP_INST     : canonical NOP (addi x0,x0,0) used for bubbles
//   if_id_t      : contents of the IF/ID pipeline register
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [ILEN-1:0] inst;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg
//   The IF/ID pipeline register with hold, bubble and load behaviour.
//   Ports:
//     clk     in   rising-edge clock
//     rst_n   in   synchronous reset, active low
//     bubble  in   squash: clear valid, force NOP, keep pc/pc4
//     hold    in   keep every field (ignored while bubble is high)
//     d       in   next contents when neither bubble nor hold
//     q       out  current register contents
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   bubble,
    input  logic   hold,
    input  if_id_t d,
    output if_id_t q
);

    // Bubble outranks hold so a squashed path never survives a stall.
    // pc/pc4 are deliberately left untouched on a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q.valid <= 1'b0;
            q.pc    <= '0;
            q.pc4   <= '0;
            q.inst  <= NOP_INST;
        end else if (bubble) begin
            q.valid <= 1'b0;
            q.inst  <= NOP_INST;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   IF stage: owns the PC, drives the combinational imem address and
//   registers the returned word into IF/ID. Redirects from EX squash the
//   instruction in IF/ID; out-of-range fetches turn into NOP bubbles.
//   Ports:
//     clk, rst_n     clock, synchronous active-low reset
//     stall          hold PC and IF/ID (load-use hazard)
//     redirect       taken branch/jump from EX, target in redirect_pc
//     imem_addr      byte address to imem (the PC register)
//     imem_inst      instruction word returned by imem in the same cycle
//     id_valid/id_pc/id_pc4/id_inst   IF/ID register outputs
//     fetch_fault    sticky flag: out-of-range fetch or misaligned redirect
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     IMEM_WORDS = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_inst,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic [ILEN-1:0] id_inst,
    output logic            fetch_fault
);

    // Word-index limit, compared against pc[31:2].
    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            in_range;
    logic            misaligned;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    assign pc_plus4   = pc + 32'd4;
    assign in_range   = (pc[31:2] < IMEM_LIMIT);
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign imem_addr  = pc;

    // Out-of-range fetches still record their pc so later stages can
    // attribute the fault, but carry no valid instruction.
    always_comb begin
        if_id_d.valid = in_range;
        if_id_d.pc    = pc;
        if_id_d.pc4   = pc_plus4;
        if_id_d.inst  = in_range ? imem_inst : NOP_INST;
    end

    // Next-PC priority: redirect, then stall, then sequential. Redirect
    // targets are forced to word alignment; wrap past 0xFFFF_FFFC is natural.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= {redirect_pc[31:2], 2'b00};
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

    // Sticky fault; the PC keeps running, a later block decides what to do.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_fault <= 1'b0;
        end else if (redirect) begin
            if (misaligned) begin
                fetch_fault <= 1'b1;
            end
        end else if (!stall && !in_range) begin
            fetch_fault <= 1'b1;
        end
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (redirect),
        .hold   (stall),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    assign id_valid = if_id_q.valid;
    assign id_pc    = if_id_q.pc;
    assign id_pc4   = if_id_q.pc4;
    assign id_inst  = if_id_q.inst;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Scoreboard bench for fetch_stage. The stimulus process drives inputs on
//   the falling edge and queues the hand-computed outputs expected after the
//   next rising edge; the monitor pops and compares just after each rising edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        int          step;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        fault;
    } expect_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic        fetch_fault;

    expect_t exp_q[$];
    int      compared   = 0;
    int      mismatched = 0;
    int      step_no    = 0;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_inst   (imem_inst),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_inst     (id_inst),
        .fetch_fault (fetch_fault)
    );

    // Imem model: word i holds 32'h1000_0000 + i (combinational read).
    assign imem_inst = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison, counted; prints a FAIL line on disagreement.
    task automatic checkOutput(input int step, input string name,
                               input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL step %0d %s: got %h expected %h", step, name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the edge.
    task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                 input logic [31:0] rpc,
                                 input logic [31:0] e_addr, input logic e_valid,
                                 input logic [31:0] e_pc, input logic [31:0] e_pc4,
                                 input logic [31:0] e_inst, input logic e_fault);
        expect_t e;
        @(negedge clk);
        rst_n       = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        step_no++;
        e.step  = step_no;
        e.addr  = e_addr;
        e.valid = e_valid;
        e.pc    = e_pc;
        e.pc4   = e_pc4;
        e.inst  = e_inst;
        e.fault = e_fault;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a fresh output set after every rising edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e.step, "imem_addr", imem_addr, e.addr);
                checkOutput(e.step, "id_valid", {31'd0, id_valid}, {31'd0, e.valid});
                checkOutput(e.step, "id_pc", id_pc, e.pc);
                checkOutput(e.step, "id_pc4", id_pc4, e.pc4);
                checkOutput(e.step, "id_inst", id_inst, e.inst);
                checkOutput(e.step, "fetch_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
            end
        end
    end

    initial begin
        int waited;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;

        //           rst  stl  rd   rpc            addr          v     pc            pc4           inst          flt
        // reset
        applyStimulus(1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0, 32'h0,        32'h0,        NOP,          1'b0);
        // free run
        applyStimulus(1'b1,1'b0,1'b0,32'h0,        32'h4,        1'b1, 32'h0,        32'h4,        32'h1000_0000,1'b0);
        applyStimulus(1'b1,1'b0,1'b0,32'h0,        32'h8,        1'b1, 32'h4,        32'h8,        32'h1000_0001,1'b0);
        // stall two cycles at pc=8, then release
        applyStimulus(1'b1,1'b1,1'b0,32'h0,        32'h8,        1'b1, 32'h4,        32'h8,        32'h1000_0001,1'b0);
        applyStimulus(1'b1,1'b1,1'b0,32'h0,        32'h8,        1'b1, 32'h4,        32'h8,        32'h1000_0001,1'b0);
        applyStimulus(1'b1,1'b0,1'b0,32'h0,        32'hC,        1'b1, 32'h8,        32'hC,        32'h1000_0002,1'b0);
        // redirect to 0x20 at pc=12
        applyStimulus(1'b1,1'b0,1'b1,32'h20,       32'h20,       1'b0, 32'h8,        32'hC,        NOP,          1'b0);
        applyStimulus(1'b1,1'b0,1'b0,32'h0,        32'h24,       1'b1, 32'h20,       32'h24,       32'h1000_0008,1'b0);
        // redirect and stall together, then stall alone, then run
        applyStimulus(1'b1,1'b1,1'b1,32'h40,       32'h40,       1'b0, 32'h20,       32'h24,       NOP,          1'b0);
        applyStimulus(1'b1,1'b1,1'b0,32'h0,        32'h40,       1'b0, 32'h20,       32'h24,       NOP,          1'b0);
        applyStimulus(1'b1,1'b0,1'b0,32'h0,        32'h44,       1'b1, 32'h40,       32'h44,       32'h1000_0010,1'b0);
        // misaligned redirect: aligned target taken, fault set and sticky
        applyStimulus(1'b1,1'b0,1'b1,32'h22,       32'h20,       1'b0, 32'h40,       32'h44,       NOP,          1'b1);
        applyStimulus(1'b1,1'b0,1'b0,32'h0,        32'h24,       1'b1, 32'h20,       32'h24,       32'h1000_0008,1'b1);
        // reset clears fault, then last legal word and first illegal one
        applyStimulus(1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0, 32'h0,        32'h0,        NOP,          1'b0);
        applyStimulus(1'b1,1'b0,1'b1,32'hFC,       32'hFC,       1'b0, 32'h0,        32'h0,        NOP,          1'b0);
        applyStimulus(1'b1,1'b0,1'b0,32'h0,        32'h100,      1'b1, 32'hFC,       32'h100,      32'h1000_003F,1'b0);
        applyStimulus(1'b1,1'b0,1'b0,32'h0,        32'h104,      1'b0, 32'h100,      32'h104,      NOP,          1'b1);
        applyStimulus(1'b1,1'b1,1'b0,32'h0,        32'h104,      1'b0, 32'h100,      32'h104,      NOP,          1'b1);
        // PC wrap from 0xFFFF_FFFC to 0
        applyStimulus(1'b1,1'b0,1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC,1'b0, 32'h100,      32'h104,      NOP,          1'b1);
        applyStimulus(1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0, 32'hFFFF_FFFC,32'h0,        NOP,          1'b1);
        applyStimulus(1'b1,1'b0,1'b0,32'h0,        32'h4,        1'b1, 32'h0,        32'h4,        32'h1000_0000,1'b1);
        // reset overrides stall and redirect; first fetch held by stall
        applyStimulus(1'b0,1'b1,1'b1,32'h33,       32'h0,        1'b0, 32'h0,        32'h0,        NOP,          1'b0);
        applyStimulus(1'b1,1'b1,1'b0,32'h0,        32'h0,        1'b0, 32'h0,        32'h0,        NOP,          1'b0);
        applyStimulus(1'b1,1'b0,1'b0,32'h0,        32'h4,        1'b1, 32'h0,        32'h4,        32'h1000_0000,1'b0);
        applyStimulus(1'b1,1'b0,1'b0,32'h0,        32'h8,        1'b1, 32'h4,        32'h8,        32'h1000_0001,1'b0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
